fib_call_adapter: RTL

//  Upstream front-end for the generated fib compute core (r_enable/w_enable protocol).

---
 rtl/fib_call_adapter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fib_call_adapter.sv
// fib_call_adapter: valid/ready front-end that launches one fib core call per request.
// Optional watchdog abort enabled by defining FIB_TIMEOUT_EN.
`default_nettype none

module fib_call_adapter #(
    parameter int N_W        = 6,
    parameter int D_W        = 32,
    parameter int TMO_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [N_W-1:0] req_n_i,
    input  logic [D_W-1:0] req_a_i,
    input  logic [D_W-1:0] req_b_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [D_W-1:0] rsp_data_o,
    output logic           rsp_err_o,
    output logic           busy_o,
    output logic           fib_r_enable_o,
    output logic [N_W-1:0] fib_init_n_o,
    output logic [D_W-1:0] fib_init_a_o,
    output logic [D_W-1:0] fib_init_b_o,
    input  logic           fib_w_enable_i,
    input  logic [D_W-1:0] fib_result_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [N_W-1:0] init_n_q;
    logic [D_W-1:0] init_a_q, init_b_q;
    logic [D_W-1:0] rsp_data_q;
    logic           accept;
    logic           done;
    logic           timeout;

    assign accept = (state_q == S_IDLE) && rst_n && req_valid_i;
    assign done   = (state_q == S_WAIT) && fib_w_enable_i;

`ifdef FIB_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TMO_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

    logic [WD_W-1:0] wdog_q;
    logic            rsp_err_q;

    // Counter holds the number of WAIT cycles already elapsed, so the
    // TMO_CYCLES-th WAIT cycle is the one that aborts.
    assign timeout = (state_q == S_WAIT) && !fib_w_enable_i && (wdog_q >= WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                wdog_q <= '0;
            end else if (state_q == S_WAIT && wdog_q != WD_MAX) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (done) begin
                rsp_err_q <= 1'b0;
            end else if (timeout) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT;
            S_WAIT:  if (done || timeout) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = (state_q == S_IDLE) && rst_n;
        fib_r_enable_o = (state_q == S_LOAD);
        busy_o         = (state_q == S_LOAD) || (state_q == S_WAIT);
        rsp_valid_o    = (state_q == S_RESP);
    end

    // Operands stay on the core inputs until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_n_q   <= '0;
            init_a_q   <= '0;
            init_b_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                init_n_q <= req_n_i;
                init_a_q <= req_a_i;
                init_b_q <= req_b_i;
            end
            if (done) begin
                rsp_data_q <= fib_result_i;
            end else if (timeout) begin
                rsp_data_q <= '0;
            end
        end
    end

    assign fib_init_n_o = init_n_q;
    assign fib_init_a_o = init_a_q;
    assign fib_init_b_o = init_b_q;
    assign rsp_data_o   = rsp_data_q;

endmodule

`default_nettype wire
